// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the execute stage: fixed-latency multiply, radix-2 restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| complete in one cycle.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [2:0]      op,
  input  logic            cut,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            e_wait,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int MCW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  function automatic logic [XLEN-1:0] fit(input logic c, input logic [XLEN-1:0] v);
    return c ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic            cut_reg;
  logic [XLEN-1:0] a_reg, b_reg;
  logic            q_neg_reg, r_neg_reg;
  logic [XLEN-1:0] quo_reg, rem_reg, dsr_reg;
  logic [6:0]      div_cnt_reg;
  logic [MCW-1:0]  mul_cnt_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;

  // Decode of the incoming request, evaluated while IDLE
  logic            ext_signed, div_signed, a_neg, b_neg;
  logic [2:0]      eff_op;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_val;
  logic            div_zero, div_ovf, early, special;

  always_comb begin
    ext_signed  = op[2] ? ~op[0] : 1'b1;
    eff_op      = (cut && !op[2]) ? 3'b000 : op;
    a_ext       = cut ? {{(XLEN-32){ext_signed & a[31]}}, a[31:0]} : a;
    b_ext       = cut ? {{(XLEN-32){ext_signed & b[31]}}, b[31:0]} : b;
    div_signed  = op[2] & ~op[0];
    a_neg       = div_signed & a_ext[XLEN-1];
    b_neg       = div_signed & b_ext[XLEN-1];
    a_mag       = a_neg ? -a_ext : a_ext;
    b_mag       = b_neg ? -b_ext : b_ext;
    min_val     = cut ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero    = (b_ext == '0);
    div_ovf     = div_signed && (a_ext == min_val) && (b_ext == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early       = (a_mag < b_mag);
`else
    early       = 1'b0;
`endif
    special     = div_zero | div_ovf | early;
    special_val = '0;
    if (div_zero)
      special_val = op[1] ? a_ext : '1;
    else if (div_ovf)
      special_val = op[1] ? '0 : min_val;
    else if (early)
      special_val = op[1] ? a_ext : '0;
  end

  // Operands are extended to 2*XLEN, so the wrapped product is exact for every signedness mix
  logic            mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_a_sgn = (op_reg == 2'b01) || (op_reg == 2'b10);
    mul_b_sgn = (op_reg == 2'b01);
    mul_a     = {{XLEN{mul_a_sgn & a_reg[XLEN-1]}}, a_reg};
    mul_b     = {{XLEN{mul_b_sgn & b_reg[XLEN-1]}}, b_reg};
    prod      = mul_a * mul_b;
    mul_res   = (op_reg == 2'b00) ? fit(cut_reg, prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
  end

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix, fix_res;

  always_comb begin
    rem_sh   = {rem_reg, quo_reg[XLEN-1]};
    fits     = (rem_sh >= {1'b0, dsr_reg});
    rem_next = fits ? (rem_sh[XLEN-1:0] - dsr_reg) : rem_sh[XLEN-1:0];
    quo_next = {quo_reg[XLEN-2:0], fits};
    quo_fix  = q_neg_reg ? -quo_reg : quo_reg;
    rem_fix  = r_neg_reg ? -rem_reg : rem_reg;
    fix_res  = fit(cut_reg, op_reg[1] ? rem_fix : quo_fix);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      cut_reg     <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dsr_reg     <= '0;
      div_cnt_reg <= '0;
      mul_cnt_reg <= '0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
    end else if (flush) begin
      state_reg <= S_IDLE;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            op_reg    <= eff_op[1:0];
            cut_reg   <= cut;
            a_reg     <= a_ext;
            b_reg     <= b_ext;
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
            if (!eff_op[2]) begin
              mul_cnt_reg <= MCW'(MUL_CYCLES);
              state_reg   <= S_MUL;
            end else if (special) begin
              result_reg <= fit(cut, special_val);
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              // Word divides park the dividend in the top half so 32 steps consume it
              quo_reg     <= cut ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
              rem_reg     <= '0;
              dsr_reg     <= b_mag;
              div_cnt_reg <= cut ? 7'd32 : 7'(XLEN);
              state_reg   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          mul_cnt_reg <= mul_cnt_reg - MCW'(1);
          if (mul_cnt_reg == MCW'(1)) begin
            result_reg <= mul_res;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end
        end
        S_DIV: begin
          rem_reg     <= rem_next;
          quo_reg     <= quo_next;
          div_cnt_reg <= div_cnt_reg - 7'd1;
          if (div_cnt_reg == 7'd1)
            state_reg <= S_FIX;
        end
        S_FIX: begin
          result_reg <= fix_res;
          done_reg   <= 1'b1;
          state_reg  <= S_DONE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign e_wait = ((state_reg == S_IDLE) && req_valid && !flush) ||
                  (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (XLEN=64, MUL_CYCLES=3); honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid, cut, flush;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        e_wait, done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 66;
`endif

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_ctrl #(.MUL_CYCLES(3), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .cut(cut),
    .a(a), .b(b), .flush(flush), .e_wait(e_wait), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Counts cycles from the request cycle to the done cycle; e_wait must be high until done, low on done
  task automatic wait_done(output int lat, output bit ew_ok);
    ew_ok = 1'b1;
    lat   = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        if (e_wait !== 1'b0) ew_ok = 1'b0;
        break;
      end else if (e_wait !== 1'b1) begin
        ew_ok = 1'b0;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic c,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int exp_lat);
    int   lat;
    bit   ew_ok;
    logic ew0;
    @(negedge clk);
    op = o; cut = c; a = x; b = y; req_valid = 1'b1;
    #1 ew0 = e_wait;
    wait_done(lat, ew_ok);
    req_valid = 1'b0;
    check({tag, " result"}, result, exp);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " e_wait"}, {63'b0, ew0 & ew_ok}, 64'd1);
    $display("op %s a=%h b=%h cut=%0b -> result=%h latency=%0d", tag, x, y, c, result, lat);
  endtask

  initial begin
    int  lat;
    bit  ew_ok;
    bit  seen;

    reset = 1'b1; req_valid = 1'b0; cut = 1'b0; flush = 1'b0; op = MUL; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset e_wait", {63'b0, e_wait}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", result, 64'd0);
    reset = 1'b0;

    // Multiplies
    run_op("MUL 7*-3", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 4);
    @(negedge clk);
    check("done one cycle", {63'b0, done}, 64'd0);
    check("result held", result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("MULHU ones*2", MULHU, 1'b0, ONES, 64'd2, 64'd1, 4);
    run_op("MULH -1*-1", MULH, 1'b0, ONES, ONES, 64'd0, 4);
    run_op("MULHSU -1*max", MULHSU, 1'b0, ONES, ONES, ONES, 4);
    run_op("MULHU max*max", MULHU, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 4);
    run_op("MULH min*2", MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, ONES, 4);
    run_op("MULW", MUL, 1'b1, 64'hDEAD_BEEF_0000_0003, 64'h4000_0000, 64'hFFFF_FFFF_C000_0000, 4);
    run_op("MULHU cut", MULHU, 1'b1, 64'hDEAD_BEEF_0000_0003, 64'h4000_0000, 64'hFFFF_FFFF_C000_0000, 4);

    // Divides, full path
    run_op("DIV -7/2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("REM -7/2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
    run_op("DIVU 100/7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    run_op("REMU 100/7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    run_op("DIV 8/-3", DIV, 1'b0, 64'd8, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("REM 8/-3", REM, 1'b0, 64'd8, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 66);
    run_op("DIV min/1", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 66);
    run_op("DIVU max/1", DIVU, 1'b0, ONES, 64'd1, ONES, 66);
    run_op("DIVW -7/2", DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run_op("REMW -7/2", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 34);
    run_op("DIVUW", DIVU, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0010, 64'h0000_0000_0FFF_FFFF, 34);
    run_op("REMUW", REMU, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0010, 64'd9, 34);

    // Special cases
    run_op("DIVW ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("REMW ovf", REM, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, 1);
    run_op("DIV ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1);
    run_op("DIVU 5/0", DIVU, 1'b0, 64'd5, 64'd0, ONES, 1);
    run_op("REM 5/0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 1);

    // Small dividend: early-out latency depends on the build
    run_op("DIVU 3/10", DIVU, 1'b0, 64'd3, 64'd10, 64'd0, EO_LAT);
    run_op("REMU 3/10", REMU, 1'b0, 64'd3, 64'd10, 64'd3, EO_LAT);
    run_op("REM -3/10", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, EO_LAT);

    // Back-to-back multiplies with req_valid held
    @(negedge clk);
    op = MUL; cut = 1'b0; a = 64'd7; b = 64'hFFFF_FFFF_FFFF_FFFD; req_valid = 1'b1;
    wait_done(lat, ew_ok);
    check("b2b first latency", 64'(lat), 64'd4);
    check("b2b first result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    a = 64'd5; b = 64'd6;
    wait_done(lat, ew_ok);
    req_valid = 1'b0;
    check("b2b second latency", 64'(lat), 64'd5);
    check("b2b second result", result, 64'd30);
    $display("op b2b MUL pair -> result=%h second latency=%0d", result, lat);

    // Flush during a divide, then a multiply straight after
    @(negedge clk);
    op = DIVU; cut = 1'b0; a = 64'd100; b = 64'd7; req_valid = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done === 1'b1) seen = 1'b1;
    flush = 1'b0; op = MUL; a = 64'd12; b = 64'd11;
    check("flush no done", {63'b0, seen}, 64'd0);
    check("flush result kept", result, 64'd30);
    wait_done(lat, ew_ok);
    req_valid = 1'b0;
    check("post-flush MUL latency", 64'(lat), 64'd4);
    check("post-flush MUL result", result, 64'd132);
    $display("op flush DIVU then MUL 12*11 -> result=%h latency=%0d", result, lat);

    // Flush beats accept in IDLE
    @(negedge clk);
    op = MUL; a = 64'd3; b = 64'd3; req_valid = 1'b1; flush = 1'b1;
    #1 check("flush blocks e_wait", {63'b0, e_wait}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || e_wait === 1'b1) seen = 1'b1;
    end
    check("flush blocks accept", {63'b0, seen}, 64'd0);
    $display("op flush-vs-accept MUL 3*3 -> activity=%0b", seen);

    // Reset mid-multiply clears result
    @(negedge clk);
    op = MUL; a = 64'd9; b = 64'd9; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset result", result, 64'd0);
    check("mid reset e_wait", {63'b0, e_wait}, 64'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("mid reset no done", {63'b0, seen}, 64'd0);
    $display("op reset mid MUL 9*9 -> result=%h done_seen=%0b", result, seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
